// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: ALU op codes, opcode/funct values and the
// ID/EXE control bundle used by the EXE-stage ALU issue logic.
package mips_pkg;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;
  localparam logic [3:0] ALUC_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Control bits carried through ID/EXE: evalid, ewreg, em2reg, ewmem, ealuimm, illegal, ealuc
  localparam int CTRL_W = 10;

  typedef struct packed {
    logic       evalid;
    logic       ewreg;
    logic       em2reg;
    logic       ewmem;
    logic       ealuimm;
    logic       illegal;
    logic [3:0] ealuc;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS op/funct decoder producing EXE control and the ALU op code.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic       wreg_o,
  output logic       m2reg_o,
  output logic       wmem_o,
  output logic       aluimm_o,
  output logic       sext_o,
  output logic       uses_rt_o,
  output logic       regrt_o,
  output logic [3:0] aluc_o,
  output logic       legal_o
);

  always_comb begin
    wreg_o    = 1'b0;
    m2reg_o   = 1'b0;
    wmem_o    = 1'b0;
    aluimm_o  = 1'b0;
    sext_o    = 1'b1;
    uses_rt_o = 1'b0;
    regrt_o   = 1'b0;
    aluc_o    = ALUC_AND;
    legal_o   = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        uses_rt_o = 1'b1;
        wreg_o    = 1'b1;
        legal_o   = 1'b1;
        case (func_i)
          FN_ADD:  aluc_o = ALUC_ADD;
          FN_SUB:  aluc_o = ALUC_SUB;
          FN_AND:  aluc_o = ALUC_AND;
          FN_OR:   aluc_o = ALUC_OR;
          FN_NOR:  aluc_o = ALUC_NOR;
          FN_SLT:  aluc_o = ALUC_SLT;
          default: begin
            legal_o = 1'b0;
            wreg_o  = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        wreg_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1; aluc_o = ALUC_ADD; legal_o = 1'b1;
      end
      OP_ANDI: begin
        wreg_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1; sext_o = 1'b0;
        aluc_o = ALUC_AND; legal_o = 1'b1;
      end
      OP_ORI: begin
        wreg_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1; sext_o = 1'b0;
        aluc_o = ALUC_OR; legal_o = 1'b1;
      end
      OP_SLTI: begin
        wreg_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1; aluc_o = ALUC_SLT; legal_o = 1'b1;
      end
      OP_LW: begin
        wreg_o = 1'b1; m2reg_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1;
        aluc_o = ALUC_ADD; legal_o = 1'b1;
      end
      OP_SW: begin
        wmem_o = 1'b1; aluimm_o = 1'b1; regrt_o = 1'b1; uses_rt_o = 1'b1;
        aluc_o = ALUC_ADD; legal_o = 1'b1;
      end
      OP_BEQ: begin
        uses_rt_o = 1'b1; regrt_o = 1'b1; aluc_o = ALUC_SUB; legal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_exe_alu_issue.sv
// ID-side issue into the EXE stage: decode, load-use hazard detection,
// immediate extension and the ID/EXE pipeline register with bubble insertion.
module id_exe_alu_issue
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    op,
  input  logic [5:0]    func,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  input  logic [DW-1:0] dqa,
  input  logic [DW-1:0] dqb,
  input  logic [15:0]   imm16,
  input  logic          flush,
  output logic          stall,
  output logic          illegal,
  output logic          evalid,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ealuimm,
  output logic [3:0]    ealuc,
  output logic [DW-1:0] eqa,
  output logic [DW-1:0] eqb,
  output logic [DW-1:0] eimm,
  output logic [RW-1:0] ern
);

  logic       dec_wreg, dec_m2reg, dec_wmem, dec_aluimm, dec_sext;
  logic       dec_uses_rt, dec_regrt, dec_legal;
  logic [3:0] dec_aluc;

  alu_ctrl_decode u_dec (
    .op_i      (op),
    .func_i    (func),
    .wreg_o    (dec_wreg),
    .m2reg_o   (dec_m2reg),
    .wmem_o    (dec_wmem),
    .aluimm_o  (dec_aluimm),
    .sext_o    (dec_sext),
    .uses_rt_o (dec_uses_rt),
    .regrt_o   (dec_regrt),
    .aluc_o    (dec_aluc),
    .legal_o   (dec_legal)
  );

  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] eqa_q, eqa_d, eqb_q, eqb_d, eimm_q, eimm_d;
  logic [RW-1:0] ern_q, ern_d;
  logic [RW-1:0] dest;
  logic [DW-1:0] imm_ext;

  assign dest    = dec_regrt ? rt : rd;
  assign imm_ext = dec_sext ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};

  // A load in EXE whose target is read by the instruction in ID cannot forward in time
  assign stall = rst_n & id_valid & ctrl_q.evalid & ctrl_q.em2reg & (ern_q != '0) &
                 ((ern_q == rs) | ((ern_q == rt) & dec_uses_rt));

  always_comb begin
    ctrl_d = '0;
    eqa_d  = '0;
    eqb_d  = '0;
    eimm_d = '0;
    ern_d  = '0;
    if (!flush && !stall && id_valid) begin
      if (dec_legal) begin
        ctrl_d.evalid  = 1'b1;
        ctrl_d.ewreg   = dec_wreg & (dest != '0);
        ctrl_d.em2reg  = dec_m2reg;
        ctrl_d.ewmem   = dec_wmem;
        ctrl_d.ealuimm = dec_aluimm;
        ctrl_d.ealuc   = dec_aluc;
        eqa_d          = dqa;
        eqb_d          = dqb;
        eimm_d         = imm_ext;
        ern_d          = dest;
      end else begin
        ctrl_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      eqa_q  <= '0;
      eqb_q  <= '0;
      eimm_q <= '0;
      ern_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      eqa_q  <= eqa_d;
      eqb_q  <= eqb_d;
      eimm_q <= eimm_d;
      ern_q  <= ern_d;
    end
  end

  assign evalid  = ctrl_q.evalid;
  assign ewreg   = ctrl_q.ewreg;
  assign em2reg  = ctrl_q.em2reg;
  assign ewmem   = ctrl_q.ewmem;
  assign ealuimm = ctrl_q.ealuimm;
  assign illegal = ctrl_q.illegal;
  assign ealuc   = ctrl_q.ealuc;
  assign eqa     = eqa_q;
  assign eqb     = eqb_q;
  assign eimm    = eimm_q;
  assign ern     = ern_q;

endmodule

// File: tb/tb_id_exe_alu_issue.sv
// Self-checking bench for id_exe_alu_issue: directed scenarios then random
// instruction streams checked against a cycle-level reference of the EXE stage.
module tb_id_exe_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [31:0] dqa, dqb;
  logic [15:0] imm16;
  logic        stall, illegal, evalid, ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [31:0] eqa, eqb, eimm;
  logic [4:0]  ern;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_exe_alu_issue #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .dqa(dqa), .dqb(dqb), .imm16(imm16), .flush(flush),
    .stall(stall), .illegal(illegal), .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ealuimm(ealuimm), .ealuc(ealuc), .eqa(eqa), .eqb(eqb),
    .eimm(eimm), .ern(ern)
  );

  typedef struct {
    logic        evalid, ewreg, em2reg, ewmem, ealuimm, illegal;
    logic [3:0]  ealuc;
    logic [31:0] eqa, eqb, eimm;
    logic [4:0]  ern;
  } exe_t;

  exe_t m;
  logic last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exe_t bubble();
    exe_t b;
    b.evalid = 0; b.ewreg = 0; b.em2reg = 0; b.ewmem = 0; b.ealuimm = 0; b.illegal = 0;
    b.ealuc = 4'b0000; b.eqa = 0; b.eqb = 0; b.eimm = 0; b.ern = 0;
    return b;
  endfunction

  // Instruction semantics straight from the ISA table: what a legal instruction puts in EXE
  function automatic exe_t ref_issue(input logic [5:0] o, input logic [5:0] f,
                                     input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [31:0] a,
                                     input logic [31:0] b, input logic [15:0] im,
                                     output logic ok);
    exe_t e = bubble();
    logic [31:0] sx, zx;
    logic writes;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    ok = 1; writes = 0;
    e.eqa = a; e.eqb = b; e.eimm = sx; e.ern = t; e.evalid = 1;
    if (o == 6'b000000) begin
      e.ern = d; writes = 1;
      if      (f == 6'b100000) e.ealuc = 4'b0010;
      else if (f == 6'b100010) e.ealuc = 4'b0110;
      else if (f == 6'b100100) e.ealuc = 4'b0000;
      else if (f == 6'b100101) e.ealuc = 4'b0001;
      else if (f == 6'b100111) e.ealuc = 4'b1100;
      else if (f == 6'b101010) e.ealuc = 4'b0111;
      else ok = 0;
    end
    else if (o == 6'b001000) begin writes = 1; e.ealuimm = 1; e.ealuc = 4'b0010; end
    else if (o == 6'b001100) begin writes = 1; e.ealuimm = 1; e.ealuc = 4'b0000; e.eimm = zx; end
    else if (o == 6'b001101) begin writes = 1; e.ealuimm = 1; e.ealuc = 4'b0001; e.eimm = zx; end
    else if (o == 6'b001010) begin writes = 1; e.ealuimm = 1; e.ealuc = 4'b0111; end
    else if (o == 6'b100011) begin writes = 1; e.ealuimm = 1; e.ealuc = 4'b0010; e.em2reg = 1; end
    else if (o == 6'b101011) begin e.ealuimm = 1; e.ealuc = 4'b0010; e.ewmem = 1; end
    else if (o == 6'b000100) begin e.ealuc = 4'b0110; end
    else ok = 0;
    e.ewreg = writes && (e.ern != 0);
    if (!ok) begin
      e = bubble();
      e.illegal = 1;
    end
    return e;
  endfunction

  // One ID cycle: drive, check stall before the edge, check EXE after it
  task automatic step(input logic rn, input logic v, input logic fl,
                      input logic [5:0] o, input logic [5:0] f,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    logic ok, uses_rt, exp_stall;
    exe_t nxt;
    rst_n = rn; id_valid = v; flush = fl; op = o; func = f;
    rs = s; rt = t; rd = d; dqa = a; dqb = b; imm16 = im;
    #1;
    uses_rt = (o == 6'b000000) || (o == 6'b101011) || (o == 6'b000100);
    exp_stall = rn && v && m.evalid && m.em2reg && (m.ern != 0) &&
                ((m.ern == s) || ((m.ern == t) && uses_rt));
    last_stall = stall;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    nxt = ref_issue(o, f, s, t, d, a, b, im, ok);
    if (!rn || fl || exp_stall || !v) nxt = bubble();
    @(posedge clk);
    #1;
    m = nxt;
    chk("evalid",  {31'b0, evalid},  {31'b0, m.evalid});
    chk("ewreg",   {31'b0, ewreg},   {31'b0, m.ewreg});
    chk("em2reg",  {31'b0, em2reg},  {31'b0, m.em2reg});
    chk("ewmem",   {31'b0, ewmem},   {31'b0, m.ewmem});
    chk("ealuimm", {31'b0, ealuimm}, {31'b0, m.ealuimm});
    chk("illegal", {31'b0, illegal}, {31'b0, m.illegal});
    chk("ealuc",   {28'b0, ealuc},   {28'b0, m.ealuc});
    chk("eqa",  eqa,  m.eqa);
    chk("eqb",  eqb,  m.eqb);
    chk("eimm", eimm, m.eimm);
    chk("ern",  {27'b0, ern}, {27'b0, m.ern});
  endtask

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] F_ADD = 6'b100000;

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [7];
    ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b100011,
            6'b101011, 6'b000100, 6'b111111, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b100001};
    m = bubble();
    rst_n = 0; id_valid = 0; flush = 0; op = 0; func = 0;
    rs = 0; rt = 0; rd = 0; dqa = 0; dqb = 0; imm16 = 0;
    @(posedge clk); #1;
    // reset state
    step(0, 1, 0, 6'b100011, 0, 1, 2, 3, 32'h11, 32'h22, 16'h0004);
    chk("rst_evalid", {31'b0, evalid}, 32'd0);

    // 1. add $3,$1,$2
    step(1, 1, 0, RT, F_ADD, 1, 2, 3, 32'd5, 32'd7, 16'h0000);
    chk("t1_ealuc", {28'b0, ealuc}, 32'h2);
    chk("t1_ern", {27'b0, ern}, 32'd3);
    chk("t1_eqa", eqa, 32'd5);
    chk("t1_eqb", eqb, 32'd7);

    // 2. andi / slti extension
    step(1, 1, 0, 6'b001100, 0, 1, 2, 0, 32'd1, 32'd2, 16'hFFF0);
    chk("t2_andi_imm", eimm, 32'h0000FFF0);
    step(1, 1, 0, 6'b001010, 0, 1, 2, 0, 32'd1, 32'd2, 16'hFFF0);
    chk("t2_slti_imm", eimm, 32'hFFFFFFF0);
    chk("t2_slti_aluc", {28'b0, ealuc}, 32'h7);

    // 3. lw $4 then add $5,$4,$1
    step(1, 1, 0, 6'b100011, 0, 1, 4, 0, 32'd100, 32'd0, 16'h0008);
    step(1, 1, 0, RT, F_ADD, 4, 1, 5, 32'd9, 32'd8, 16'h0000);
    chk("t3_stall", {31'b0, last_stall}, 32'd1);
    chk("t3_bubble", {31'b0, evalid}, 32'd0);
    step(1, 1, 0, RT, F_ADD, 4, 1, 5, 32'd9, 32'd8, 16'h0000);
    chk("t3_nostall", {31'b0, last_stall}, 32'd0);
    chk("t3_issue", {28'b0, ealuc}, 32'h2);

    // 4. flush with concurrent load-use
    step(1, 1, 0, 6'b100011, 0, 1, 6, 0, 32'd0, 32'd0, 16'h0000);
    step(1, 1, 1, RT, 6'b100010, 6, 2, 7, 32'd3, 32'd4, 16'h0000);
    chk("t4_stall", {31'b0, last_stall}, 32'd1);
    chk("t4_evalid", {31'b0, evalid}, 32'd0);

    // 5. illegal op, addi to $0
    step(1, 1, 0, 6'b111111, 0, 1, 2, 3, 32'd1, 32'd2, 16'h1234);
    chk("t5_illegal", {31'b0, illegal}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 16'h0000);
    chk("t5_pulse", {31'b0, illegal}, 32'd0);
    step(1, 1, 0, 6'b001000, 0, 1, 0, 0, 32'd1, 32'd2, 16'h0005);
    chk("t5_r0", {31'b0, ewreg}, 32'd0);

    // 6. reset with a load in EXE
    step(1, 1, 0, 6'b100011, 0, 1, 7, 0, 32'd1, 32'd2, 16'h0004);
    step(0, 1, 0, RT, F_ADD, 7, 7, 8, 32'd1, 32'd2, 16'h0000);
    chk("t6_stall", {31'b0, last_stall}, 32'd0);
    chk("t6_em2reg", {31'b0, em2reg}, 32'd0);

    // random streams over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 9)];
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 6) != 0),
           ($urandom_range(0, 9) == 0), o, fns[$urandom_range(0, 6)],
           5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
           $urandom, $urandom, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
